// File: rtl/demux_pkg.sv
// Shared constants and slot state type for the stream demultiplexer.
// Optional per-port transfer counters are enabled with DEMUX_STATS_EN.
package demux_pkg;
  localparam int MAX_PORTS = 16;
  localparam int CNT_W     = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;
endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot with valid/ready on the read side.
// A drain and a refill in the same cycle keep the slot full with no bubble.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data
);

  slot_state_t      state_reg;
  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      data_reg  <= '0;
    end else if (wr_en) begin
      state_reg <= FULL;
      data_reg  <= wr_data;
    end else if (state_reg == FULL && ready) begin
      state_reg <= EMPTY;
    end
  end

  assign valid    = (state_reg == FULL);
  assign data     = data_reg;
  assign wr_ready = (state_reg == EMPTY) || ready;

endmodule

// File: rtl/stream_demux.sv
// Steers one valid/ready stream to NUM_PORTS one-entry output slots by in_sel.
// Define DEMUX_STATS_EN to add the per-port xfer_cnt delivered-word counters.
module stream_demux
  import demux_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 32,
  localparam int SEL_W    = $clog2(NUM_PORTS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [SEL_W-1:0]                    in_sel,
  input  logic [WIDTH-1:0]                    in_data,
  output logic [NUM_PORTS-1:0]                out_valid,
  input  logic [NUM_PORTS-1:0]                out_ready,
  output logic [NUM_PORTS-1:0][WIDTH-1:0]     out_data,
  output logic                                sel_err
`ifdef DEMUX_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][CNT_W-1:0]     xfer_cnt
`endif
);

  localparam int SEL_SPAN = 2 ** SEL_W;

  logic [NUM_PORTS-1:0] slot_ready;
  logic [NUM_PORTS-1:0] wr_en;
  logic [SEL_SPAN-1:0]  ready_pad;
  logic                 sel_legal;
  logic                 sel_err_reg;

  assign sel_legal = ({1'b0, in_sel} < (SEL_W + 1)'(NUM_PORTS));

  // Unused select codes read as not-ready; they are masked by sel_legal anyway.
  genvar gi;
  generate
    for (gi = 0; gi < SEL_SPAN; gi++) begin : gen_pad
      if (gi < NUM_PORTS) begin : gen_live
        assign ready_pad[gi] = slot_ready[gi];
      end else begin : gen_dead
        assign ready_pad[gi] = 1'b0;
      end
    end
  endgenerate

  assign in_ready = !rst_n || !sel_legal || ready_pad[in_sel];

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : gen_port
      assign wr_en[gi] = in_valid && rst_n && (in_sel == SEL_W'(gi)) && slot_ready[gi];

      demux_slot #(.WIDTH(WIDTH)) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en[gi]),
        .wr_data  (in_data),
        .wr_ready (slot_ready[gi]),
        .valid    (out_valid[gi]),
        .ready    (out_ready[gi]),
        .data     (out_data[gi])
      );

`ifdef DEMUX_STATS_EN
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (out_valid[gi] && out_ready[gi]) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign xfer_cnt[gi] = cnt_reg;
`endif
    end
  endgenerate

  // Out-of-range words are always accepted, so a valid illegal select is a drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err_reg <= 1'b0;
    end else begin
      sel_err_reg <= in_valid && !sel_legal;
    end
  end

  assign sel_err = sel_err_reg;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: 4-port instance with per-port scoreboard,
// plus a 3-port instance for the illegal-select path.
module tb_stream_demux;
  localparam int NP = 4;
  localparam int W  = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [W-1:0]     in_data;
  logic [NP-1:0]    out_valid;
  logic [NP-1:0]    out_ready;
  logic [NP-1:0][W-1:0] out_data;
  logic             sel_err;

  logic             in3_valid;
  logic             in3_ready;
  logic [1:0]       in3_sel;
  logic [W-1:0]     in3_data;
  logic [2:0]       out3_valid;
  logic [2:0]       out3_ready;
  logic [2:0][W-1:0] out3_data;
  logic             sel3_err;

`ifdef DEMUX_STATS_EN
  logic [NP-1:0][15:0] xfer_cnt;
  logic [2:0][15:0]    xfer3_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] sbq[NP][$];

  always #5 clk = ~clk;

  stream_demux #(.NUM_PORTS(NP), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sel_err(sel_err)
`ifdef DEMUX_STATS_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  stream_demux #(.NUM_PORTS(3), .WIDTH(W)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in3_valid), .in_ready(in3_ready),
    .in_sel(in3_sel), .in_data(in3_data), .out_valid(out3_valid),
    .out_ready(out3_ready), .out_data(out3_data), .sel_err(sel3_err)
`ifdef DEMUX_STATS_EN
    , .xfer_cnt(xfer3_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: sample at negedge, scoreboard drains then accepts, return at posedge+1.
  task automatic cycle();
    logic exp_ready;
    @(negedge clk);
    exp_ready = !rst_n || (in_sel >= 2'(NP)) || (sbq[in_sel].size() == 0) || out_ready[in_sel];
    if (rst_n) begin
      for (int p = 0; p < NP; p++) begin
        if (out_valid[p] && out_ready[p]) begin
          if (sbq[p].size() == 0) check("drain_unexp", {32'd0, out_data[p]}, 64'hFFFF_FFFF_FFFF_FFFF);
          else check("drain_data", {32'd0, out_data[p]}, {32'd0, sbq[p].pop_front()});
        end
      end
    end
    if (in_valid) check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) sbq[p].delete();
    end else if (in_valid && exp_ready) begin
      sbq[in_sel].push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    in3_valid = 1'b0; in3_sel = '0; in3_data = '0; out3_ready = 3'b111;
    cycle(); cycle();
    rst_n = 1'b1;
    #1;
    check("rst_valid", {60'd0, out_valid}, 64'd0);
    check("rst_data", {out_data[1], out_data[0]} | {out_data[3], out_data[2]}, 64'd0);
    check("rst_selerr", {63'd0, sel_err}, 64'd0);
    check("rst_ready", {63'd0, in_ready}, 64'd1);

    // Single word to a stalled port 2
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF;
    cycle();
    in_valid = 1'b0;
    check("p2_valid", {60'd0, out_valid}, 64'h4);
    check("p2_data", {32'd0, out_data[2]}, 64'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("p2_hold", {28'd0, out_valid, out_data[2]}, {28'd0, 4'b0100, 32'hDEADBEEF});
    end
    in_valid = 1'b1; in_data = 32'h12345678;
    #1;
    check("p2_block", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    out_ready = 4'b0100;
    cycle();
    out_ready = 4'b0000;
    check("p2_empty", {60'd0, out_valid}, 64'd0);

    // Back-to-back on port 1
    out_ready = 4'b0010;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_sel = 2'd1; in_data = 32'(i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("p1_empty", {60'd0, out_valid}, 64'd0);
    check("p1_queue", 64'(sbq[1].size()), 64'd0);

    // Isolation: port 0 stalled full, port 3 flows
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hAAAA0000;
    cycle();
    out_ready = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sel = 2'd3; in_data = 32'hC0DE0000 + 32'(i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("iso_valid", {60'd0, out_valid}, 64'h1);
    check("iso_data", {32'd0, out_data[0]}, 64'hAAAA0000);
    check("iso_queue", 64'(sbq[3].size()), 64'd0);

    // Reset mid-operation with ports 0 and 1 full
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'hBBBB1111;
    cycle();
    check("pre_rst", {60'd0, out_valid}, 64'h3);
    rst_n = 1'b0; in_sel = 2'd2; in_data = 32'h55;
    cycle();
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check("mid_rst_v", {60'd0, out_valid}, 64'd0);
    check("mid_rst_d", {out_data[1], out_data[0]} | {out_data[3], out_data[2]}, 64'd0);
    check("p4_selerr", {63'd0, sel_err}, 64'd0);

    // Illegal select on the 3-port instance
    in3_valid = 1'b1; in3_sel = 2'd3; in3_data = 32'h99;
    #1;
    check("ill_ready", {63'd0, in3_ready}, 64'd1);
    check("ill_pre", {63'd0, sel3_err}, 64'd0);
    cycle();
    in3_valid = 1'b0;
    check("ill_pulse", {63'd0, sel3_err}, 64'd1);
    check("ill_nov", {61'd0, out3_valid}, 64'd0);
    cycle();
    check("ill_clear", {63'd0, sel3_err}, 64'd0);
    in3_valid = 1'b1; in3_sel = 2'd2; in3_data = 32'h77;
    cycle();
    in3_valid = 1'b0;
    check("p3_legal", {29'd0, out3_valid, out3_data[2]}, {29'd0, 3'b100, 32'h77});
    check("p3_noerr", {63'd0, sel3_err}, 64'd0);

`ifdef DEMUX_STATS_EN
    cycle();
    force dut.gen_port[0].cnt_reg = 16'hFFFE;
    cycle();
    release dut.gen_port[0].cnt_reg;
    out_ready = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hF0 + 32'(i);
      cycle();
      in_valid = 1'b0;
      cycle();
      check("xfer_cnt0", {48'd0, xfer_cnt[0]}, 64'(16'(16'hFFFF + i)));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
